// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcode/funct codes,
// FSM state codes, ALU/write-back/destination selects, instruction classes
// and the bundle of control strobes the FSM drives.
package mips_pkg;

  // Primary opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type function codes (instruction[5:0])
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_EXE_R   = 4'd2,
    ST_EXE_I   = 4'd3,
    ST_MEM_ADR = 4'd4,
    ST_MEM_RD  = 4'd5,
    ST_MEM_WR  = 4'd6,
    ST_WB_R    = 4'd7,
    ST_WB_I    = 4'd8,
    ST_WB_MEM  = 4'd9,
    ST_BRANCH  = 4'd10,
    ST_JUMP    = 4'd11
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_OR  = 3'd2,
    ALU_LUI = 3'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    DST_RT = 2'd0,
    DST_RD = 2'd1,
    DST_RA = 2'd2
  } reg_dst_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  // Instruction classes produced by mc_decode
  typedef enum logic [3:0] {
    IC_ILLEGAL = 4'd0,
    IC_ADDU    = 4'd1,
    IC_SUBU    = 4'd2,
    IC_JR      = 4'd3,
    IC_ORI     = 4'd4,
    IC_LUI     = 4'd5,
    IC_LW      = 4'd6,
    IC_SW      = 4'd7,
    IC_BEQ     = 4'd8,
    IC_J       = 4'd9,
    IC_JAL     = 4'd10
  } iclass_e;

  // Every strobe/select the controller drives, registered as one word
  typedef struct packed {
    logic     ir_wr;
    logic     pc_wr;
    logic     npc_sel;
    logic     j;
    logic     jr_ctrl;
    logic     reg_wr;
    logic     mem_wr;
    reg_dst_e reg_dst;
    wb_sel_e  wb_sel;
    logic     alu_src;
    logic     ext_op;
    alu_op_e  alu_op;
    logic     retire;
    logic     illegal;
  } ctrl_t;

  // All strobes low, all selects at their zero encoding
  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c = '0;
    return c;
  endfunction

  // States that finish an instruction unconditionally (MEM_WR finishes only
  // on its last wait cycle, so it is handled separately)
  function automatic logic is_terminal(input state_e s);
    logic t;
    case (s)
      ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JUMP: t = 1'b1;
      default:                                         t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct -> instruction class.
// Anything not in the supported subset is reported as IC_ILLEGAL.
module mc_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_e    iclass
);

  // Map the opcode (and funct for R-type) onto an instruction class
  always_comb begin
    iclass = IC_ILLEGAL;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: iclass = IC_ADDU;
          FN_SUBU: iclass = IC_SUBU;
          FN_JR:   iclass = IC_JR;
          default: iclass = IC_ILLEGAL;
        endcase
      end
      OP_ORI:  iclass = IC_ORI;
      OP_LUI:  iclass = IC_LUI;
      OP_LW:   iclass = IC_LW;
      OP_SW:   iclass = IC_SW;
      OP_BEQ:  iclass = IC_BEQ;
      OP_J:    iclass = IC_J;
      OP_JAL:  iclass = IC_JAL;
      default: iclass = IC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS controller. Moore FSM whose outputs are computed from the
// next state and the next latched opcode/funct, then registered, so every
// output is a flop and reset clears them all in the same edge as the state.
// A one-cycle hold flag keeps the FSM in FETCH (with all outputs low) for the
// reset cycle, so the first cycle after release is FETCH with ir_wr=1.
module mc_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       ir_wr,
  output logic       pc_wr,
  output logic       npc_sel,
  output logic       j,
  output logic       jr_ctrl,
  output logic       reg_wr,
  output logic       mem_wr,
  output logic [1:0] reg_dst,
  output logic [1:0] wb_sel,
  output logic       alu_src,
  output logic       ext_op,
  output logic [2:0] alu_op,
  output logic       retire,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT);

  state_e      state_r;
  logic        hold_r;
  logic [3:0]  wait_r;
  logic [5:0]  op_r;
  logic [5:0]  fn_r;
  ctrl_t       ctrl_r;

  state_e      state_nxt_s;
  logic [3:0]  wait_nxt_s;
  logic [5:0]  op_s;
  logic [5:0]  fn_s;
  iclass_e     iclass_s;
  ctrl_t       ctrl_nxt_s;

  // The IFU applies zero itself when npc_sel is set in BRANCH; the
  // controller's own decisions never depend on it.
  logic        unused_s;
  assign unused_s = zero;

  // In FETCH the instruction is being loaded, so the live opcode is the one
  // that will be latched; afterwards the latched copy is authoritative.
  assign op_s = (state_r == ST_FETCH) ? opcode : op_r;
  assign fn_s = (state_r == ST_FETCH) ? funct  : fn_r;

  mc_decode u_decode (
    .opcode (op_s),
    .funct  (fn_s),
    .iclass (iclass_s)
  );

  // Latch opcode/funct alongside the instruction-register load
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r <= 6'd0;
      fn_r <= 6'd0;
    end else if (state_r == ST_FETCH) begin
      op_r <= opcode;
      fn_r <= funct;
    end else begin
      op_r <= op_r;
      fn_r <= fn_r;
    end
  end

  // State, wait counter, reset hold flag and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_FETCH;
      hold_r  <= 1'b1;
      wait_r  <= 4'd0;
      ctrl_r  <= ctrl_idle();
    end else begin
      state_r <= state_nxt_s;
      hold_r  <= 1'b0;
      wait_r  <= wait_nxt_s;
      ctrl_r  <= ctrl_nxt_s;
    end
  end

  // Next-state and wait-counter logic
  always_comb begin
    state_nxt_s = state_r;
    if (hold_r) begin
      state_nxt_s = ST_FETCH;
    end else begin
      case (state_r)
        ST_FETCH: state_nxt_s = ST_DECODE;
        ST_DECODE: begin
          case (iclass_s)
            IC_ADDU, IC_SUBU:     state_nxt_s = ST_EXE_R;
            IC_ORI, IC_LUI:       state_nxt_s = ST_EXE_I;
            IC_LW, IC_SW:         state_nxt_s = ST_MEM_ADR;
            IC_BEQ:               state_nxt_s = ST_BRANCH;
            IC_J, IC_JAL, IC_JR:  state_nxt_s = ST_JUMP;
            default:              state_nxt_s = ST_FETCH;
          endcase
        end
        ST_EXE_R: state_nxt_s = ST_WB_R;
        ST_EXE_I: state_nxt_s = ST_WB_I;
        ST_MEM_ADR: begin
          if (iclass_s == IC_SW) state_nxt_s = ST_MEM_WR;
          else                   state_nxt_s = ST_MEM_RD;
        end
        ST_MEM_RD: begin
          if (wait_r == 4'd0) state_nxt_s = ST_WB_MEM;
          else                state_nxt_s = ST_MEM_RD;
        end
        ST_MEM_WR: begin
          if (wait_r == 4'd0) state_nxt_s = ST_FETCH;
          else                state_nxt_s = ST_MEM_WR;
        end
        ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JUMP: state_nxt_s = ST_FETCH;
        default: state_nxt_s = ST_FETCH;
      endcase
    end

    // Counter loads on entry to a memory state, then counts down to zero
    wait_nxt_s = 4'd0;
    if (((state_nxt_s == ST_MEM_RD) || (state_nxt_s == ST_MEM_WR)) &&
        (state_nxt_s != state_r)) begin
      wait_nxt_s = WAIT_LOAD;
    end else if (wait_r != 4'd0) begin
      wait_nxt_s = wait_r - 4'd1;
    end else begin
      wait_nxt_s = 4'd0;
    end
  end

  // Output decode for the upcoming state (registered on the next edge)
  always_comb begin
    ctrl_nxt_s = ctrl_idle();
    case (state_nxt_s)
      ST_FETCH: ctrl_nxt_s.ir_wr = 1'b1;
      ST_DECODE: begin
        if (iclass_s == IC_ILLEGAL) begin
          ctrl_nxt_s.illegal = 1'b1;
          ctrl_nxt_s.pc_wr   = 1'b1;
        end else begin
          ctrl_nxt_s.illegal = 1'b0;
        end
      end
      ST_EXE_R: begin
        if (iclass_s == IC_SUBU) ctrl_nxt_s.alu_op = ALU_SUB;
        else                     ctrl_nxt_s.alu_op = ALU_ADD;
      end
      ST_EXE_I: begin
        ctrl_nxt_s.alu_src = 1'b1;
        ctrl_nxt_s.ext_op  = 1'b0;
        if (iclass_s == IC_LUI) ctrl_nxt_s.alu_op = ALU_LUI;
        else                    ctrl_nxt_s.alu_op = ALU_OR;
      end
      ST_MEM_ADR, ST_MEM_RD: begin
        ctrl_nxt_s.alu_src = 1'b1;
        ctrl_nxt_s.ext_op  = 1'b1;
        ctrl_nxt_s.alu_op  = ALU_ADD;
      end
      ST_MEM_WR: begin
        ctrl_nxt_s.alu_src = 1'b1;
        ctrl_nxt_s.ext_op  = 1'b1;
        ctrl_nxt_s.alu_op  = ALU_ADD;
        // Write only once the stall has fully elapsed
        if (wait_nxt_s == 4'd0) ctrl_nxt_s.mem_wr = 1'b1;
        else                    ctrl_nxt_s.mem_wr = 1'b0;
      end
      ST_WB_R: begin
        ctrl_nxt_s.reg_wr  = 1'b1;
        ctrl_nxt_s.reg_dst = DST_RD;
        ctrl_nxt_s.wb_sel  = WB_ALU;
      end
      ST_WB_I: begin
        ctrl_nxt_s.reg_wr  = 1'b1;
        ctrl_nxt_s.reg_dst = DST_RT;
        ctrl_nxt_s.wb_sel  = WB_ALU;
        ctrl_nxt_s.alu_src = 1'b1;
        ctrl_nxt_s.ext_op  = 1'b0;
      end
      ST_WB_MEM: begin
        ctrl_nxt_s.reg_wr  = 1'b1;
        ctrl_nxt_s.reg_dst = DST_RT;
        ctrl_nxt_s.wb_sel  = WB_MEM;
      end
      ST_BRANCH: begin
        ctrl_nxt_s.alu_op  = ALU_SUB;
        ctrl_nxt_s.npc_sel = 1'b1;
      end
      ST_JUMP: begin
        case (iclass_s)
          IC_J:  ctrl_nxt_s.j = 1'b1;
          IC_JAL: begin
            ctrl_nxt_s.j       = 1'b1;
            ctrl_nxt_s.reg_wr  = 1'b1;
            ctrl_nxt_s.reg_dst = DST_RA;
            ctrl_nxt_s.wb_sel  = WB_PC4;
          end
          IC_JR:   ctrl_nxt_s.jr_ctrl = 1'b1;
          default: ctrl_nxt_s.j       = 1'b0;
        endcase
      end
      default: ctrl_nxt_s = ctrl_idle();
    endcase

    // Completing cycle: advance the PC and flag retirement
    if (is_terminal(state_nxt_s) || ctrl_nxt_s.mem_wr) begin
      ctrl_nxt_s.pc_wr  = 1'b1;
      ctrl_nxt_s.retire = 1'b1;
    end else begin
      ctrl_nxt_s.retire = 1'b0;
    end
  end

  assign ir_wr   = ctrl_r.ir_wr;
  assign pc_wr   = ctrl_r.pc_wr;
  assign npc_sel = ctrl_r.npc_sel;
  assign j       = ctrl_r.j;
  assign jr_ctrl = ctrl_r.jr_ctrl;
  assign reg_wr  = ctrl_r.reg_wr;
  assign mem_wr  = ctrl_r.mem_wr;
  assign reg_dst = ctrl_r.reg_dst;
  assign wb_sel  = ctrl_r.wb_sel;
  assign alu_src = ctrl_r.alu_src;
  assign ext_op  = ctrl_r.ext_op;
  assign alu_op  = ctrl_r.alu_op;
  assign retire  = ctrl_r.retire;
  assign illegal = ctrl_r.illegal;
  assign state   = state_r;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl. Per-cycle expected output words are pushed to a
// scoreboard queue when an instruction is driven and popped each cycle.
// Instance a uses MEM_WAIT=2; instance b (MEM_WAIT=3) covers reset mid-MEM_WR.
module tb_mc_ctrl;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BAD = 6'b111111;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_JR   = 6'b001000;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;

  logic       a_ir_wr, a_pc_wr, a_npc_sel, a_j, a_jr_ctrl, a_reg_wr, a_mem_wr;
  logic [1:0] a_reg_dst, a_wb_sel;
  logic       a_alu_src, a_ext_op, a_retire, a_illegal;
  logic [2:0] a_alu_op;
  logic [3:0] a_state;

  logic       b_ir_wr, b_pc_wr, b_npc_sel, b_j, b_jr_ctrl, b_reg_wr, b_mem_wr;
  logic [1:0] b_reg_dst, b_wb_sel;
  logic       b_alu_src, b_ext_op, b_retire, b_illegal;
  logic [2:0] b_alu_op;
  logic [3:0] b_state;

  logic [21:0] a_vec;
  logic [21:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int retire_cnt = 0;
  int b_mw_seen = 0;

  mc_ctrl #(.MEM_WAIT(2)) u_dut_a (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .ir_wr(a_ir_wr), .pc_wr(a_pc_wr), .npc_sel(a_npc_sel), .j(a_j),
    .jr_ctrl(a_jr_ctrl), .reg_wr(a_reg_wr), .mem_wr(a_mem_wr),
    .reg_dst(a_reg_dst), .wb_sel(a_wb_sel), .alu_src(a_alu_src),
    .ext_op(a_ext_op), .alu_op(a_alu_op), .retire(a_retire),
    .illegal(a_illegal), .state(a_state)
  );

  mc_ctrl #(.MEM_WAIT(3)) u_dut_b (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .ir_wr(b_ir_wr), .pc_wr(b_pc_wr), .npc_sel(b_npc_sel), .j(b_j),
    .jr_ctrl(b_jr_ctrl), .reg_wr(b_reg_wr), .mem_wr(b_mem_wr),
    .reg_dst(b_reg_dst), .wb_sel(b_wb_sel), .alu_src(b_alu_src),
    .ext_op(b_ext_op), .alu_op(b_alu_op), .retire(b_retire),
    .illegal(b_illegal), .state(b_state)
  );

  // Observed word: {state, ir,pc,npc,j,jr,rw,mw, reg_dst, wb_sel, alu_src, ext_op, alu_op, retire, illegal}
  assign a_vec = {a_state, a_ir_wr, a_pc_wr, a_npc_sel, a_j, a_jr_ctrl, a_reg_wr,
                  a_mem_wr, a_reg_dst, a_wb_sel, a_alu_src, a_ext_op, a_alu_op,
                  a_retire, a_illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // en = {ir_wr, pc_wr, npc_sel, j, jr_ctrl, reg_wr, mem_wr}
  task automatic push(input logic [3:0] st, input logic [6:0] en,
                      input logic [1:0] rd, input logic [1:0] ws,
                      input logic asrc, input logic eo, input logic [2:0] ao,
                      input logic ret, input logic ill);
    exp_q.push_back({st, en, rd, ws, asrc, eo, ao, ret, ill});
  endtask

  task automatic push_f();
    push(4'd0, 7'b1000000, 2'd0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic push_d();
    push(4'd1, 7'b0000000, 2'd0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  // Advance one cycle and sample at the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (a_retire === 1'b1) retire_cnt++;
    if (b_mem_wr !== 1'b0) b_mw_seen++;
  endtask

  // Drive one instruction, compare n cycles against the scoreboard
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int n, input int exp_ret);
    logic [21:0] e;
    opcode = op;
    funct  = fn;
    zero   = z;
    retire_cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (exp_q.size() == 0) begin
        chk($sformatf("%s_queue_underflow", tag), 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("%s_cyc%0d", tag, i + 1), {10'd0, a_vec}, {10'd0, e});
      end
    end
    chk($sformatf("%s_retire_count", tag), retire_cnt, exp_ret);
  endtask

  initial begin
    reset  = 1'b1;
    opcode = 6'd0;
    funct  = 6'd0;
    zero   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_a_outputs", {10'd0, a_vec}, 32'd0);
    chk("reset_b_state", {28'd0, b_state}, 32'd0);
    reset = 1'b0;

    // addu: 0,1,2,7
    push_f(); push_d();
    push(4'd2, 7'b0000000, 2'd0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    push(4'd7, 7'b0100010, 2'd1, 2'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    run_instr("addu", OP_R, F_ADDU, 1'b0, 4, 1);

    // subu: EXE_R with alu_op=sub
    push_f(); push_d();
    push(4'd2, 7'b0000000, 2'd0, 2'd0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
    push(4'd7, 7'b0100010, 2'd1, 2'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    run_instr("subu", OP_R, F_SUBU, 1'b0, 4, 1);

    // ori: 0,1,3,8
    push_f(); push_d();
    push(4'd3, 7'b0000000, 2'd0, 2'd0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0);
    push(4'd8, 7'b0100010, 2'd0, 2'd0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    run_instr("ori", OP_ORI, 6'd0, 1'b0, 4, 1);

    // lui: EXE_I with alu_op=lui
    push_f(); push_d();
    push(4'd3, 7'b0000000, 2'd0, 2'd0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0);
    push(4'd8, 7'b0100010, 2'd0, 2'd0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    run_instr("lui", OP_LUI, 6'd0, 1'b0, 4, 1);

    // lw with MEM_WAIT=2: 0,1,4,5,5,5,9
    push_f(); push_d();
    push(4'd4, 7'b0000000, 2'd0, 2'd0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      push(4'd5, 7'b0000000, 2'd0, 2'd0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
    push(4'd9, 7'b0100010, 2'd0, 2'd1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    run_instr("lw", OP_LW, 6'd0, 1'b0, 7, 1);

    // sw with MEM_WAIT=2: 0,1,4,6,6,6 with mem_wr only on the last
    push_f(); push_d();
    push(4'd4, 7'b0000000, 2'd0, 2'd0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
    push(4'd6, 7'b0000000, 2'd0, 2'd0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
    push(4'd6, 7'b0000000, 2'd0, 2'd0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
    push(4'd6, 7'b0100001, 2'd0, 2'd0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
    run_instr("sw", OP_SW, 6'd0, 1'b0, 6, 1);

    // beq taken / not taken: identical controller behaviour
    push_f(); push_d();
    push(4'd10, 7'b0110000, 2'd0, 2'd0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0);
    run_instr("beq_z1", OP_BEQ, 6'd0, 1'b1, 3, 1);
    push_f(); push_d();
    push(4'd10, 7'b0110000, 2'd0, 2'd0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0);
    run_instr("beq_z0", OP_BEQ, 6'd0, 1'b0, 3, 1);

    // j, jal, jr
    push_f(); push_d();
    push(4'd11, 7'b0101000, 2'd0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    run_instr("j", OP_J, 6'd0, 1'b0, 3, 1);
    push_f(); push_d();
    push(4'd11, 7'b0101010, 2'd2, 2'd2, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    run_instr("jal", OP_JAL, 6'd0, 1'b0, 3, 1);
    push_f(); push_d();
    push(4'd11, 7'b0100100, 2'd0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    run_instr("jr", OP_R, F_JR, 1'b0, 3, 1);

    // Illegal opcode and illegal R-type funct: DECODE pulses illegal + pc_wr
    push_f();
    push(4'd1, 7'b0100000, 2'd0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    run_instr("bad_op", OP_BAD, 6'd0, 1'b0, 2, 0);
    push_f();
    push(4'd1, 7'b0100000, 2'd0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    run_instr("bad_funct", OP_R, 6'b111111, 1'b0, 2, 0);

    // Back to normal after an illegal instruction
    push_f(); push_d();
    push(4'd2, 7'b0000000, 2'd0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    push(4'd7, 7'b0100010, 2'd1, 2'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    run_instr("addu_after_bad", OP_R, F_ADDU, 1'b0, 4, 1);

    // Reset during MEM_WR on instance b (MEM_WAIT=3): the write never fires
    reset = 1'b1;
    tick();
    tick();
    chk("reset2_a_outputs", {10'd0, a_vec}, 32'd0);
    reset  = 1'b0;
    opcode = OP_SW;
    funct  = 6'd0;
    b_mw_seen = 0;
    tick();
    tick();
    tick();
    tick();
    chk("b_mem_wr_entry_state", {28'd0, b_state}, 32'd6);
    tick();
    chk("b_mem_wr_wait_state", {28'd0, b_state}, 32'd6);
    reset = 1'b1;
    tick();
    chk("b_reset_state", {28'd0, b_state}, 32'd0);
    chk("b_reset_mem_wr", {31'd0, b_mem_wr}, 32'd0);
    opcode = OP_R;
    funct  = F_ADDU;
    reset  = 1'b0;
    tick();
    chk("b_release_fetch", {27'd0, b_state, b_ir_wr}, {27'd0, 4'd0, 1'b1});
    repeat (5) tick();
    chk("b_mem_wr_never", b_mw_seen, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter MEM_WAIT, default 0, extra stall cycles in each data-memory state; legal range 0..15.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 opcode  input  6  instruction[31:26] from the IFU.
REQ-005 funct  input  6  instruction[5:0] from the IFU.
REQ-006 zero  input  1  ALU equality flag.
REQ-007 ir_wr  output  1  instruction-register load strobe.
REQ-008 pc_wr  output  1  PC update strobe.
REQ-009 npc_sel, j, jr_ctrl  output  1 each  next-PC selects, same meaning as the IFU inputs.
REQ-010 reg_wr, mem_wr  output  1 each  register-file and data-memory write enables.
REQ-011 reg_dst  output  2  0 = rt, 1 = rd, 2 = $31.
REQ-012 wb_sel  output  2  0 = ALU, 1 = memory, 2 = PC+4 (jalAddr).
REQ-013 alu_src, ext_op  output  1 each  ALU B select (1 = immediate); 0 = zero-extend, 1 = sign-extend.
REQ-014 alu_op  output  3  0 = add, 1 = sub, 2 = or, 3 = lui.
REQ-015 retire  output  1  one-cycle pulse when an instruction completes.
REQ-016 illegal  output  1  one-cycle pulse on an undecodable instruction.
REQ-017 state  output  4  current FSM state code, for debug.

Function
REQ-018 Controller SHALL be a Moore FSM; all outputs SHALL be decoded from registered state plus latched opcode/funct only; zero SHALL be used only in BRANCH.
REQ-019 States and codes: FETCH 0, DECODE 1, EXE_R 2, EXE_I 3, MEM_ADR 4, MEM_RD 5, MEM_WR 6, WB_R 7, WB_I 8, WB_MEM 9, BRANCH 10, JUMP 11.
REQ-020 FETCH SHALL assert ir_wr and go to DECODE.
REQ-021 DECODE transitions: addu (000000/100001), subu (000000/100011) -> EXE_R; jr (000000/001000) -> JUMP; ori 001101, lui 001111 -> EXE_I; lw 100011, sw 101011 -> MEM_ADR; beq 000100 -> BRANCH; j 000010, jal 000011 -> JUMP; anything else -> FETCH with illegal=1 and pc_wr=1, no other enables.
REQ-022 EXE_R -> WB_R; EXE_I -> WB_I; MEM_ADR -> MEM_RD (lw) or MEM_WR (sw); MEM_RD -> WB_MEM.
REQ-023 WB_R: reg_wr=1, reg_dst=1, wb_sel=0. WB_I: reg_wr=1, reg_dst=0, wb_sel=0, alu_src=1, ext_op=0. WB_MEM: reg_wr=1, reg_dst=0, wb_sel=1.
REQ-024 MEM_WR: mem_wr=1 on its final cycle only.
REQ-025 BRANCH: alu_op=1, npc_sel=1, pc_wr=1; the IFU applies zero.
REQ-026 JUMP: pc_wr=1; j=1 for j/jal; jr_ctrl=1 for jr; for jal also reg_wr=1, reg_dst=2, wb_sel=2.
REQ-027 Terminal states WB_R, WB_I, WB_MEM, MEM_WR, BRANCH and JUMP SHALL assert pc_wr=1 and retire=1, then go to FETCH.
REQ-028 Instruction latency in cycles: R/ori/lui/sw = 4, lw = 5, beq/j/jal/jr = 3. MEM_RD and MEM_WR each add MEM_WAIT cycles.
REQ-029 Wait counter (4 bit) SHALL load MEM_WAIT on entry to MEM_RD/MEM_WR and decrement each cycle; the state SHALL exit when the counter is 0. MEM_WAIT=0 gives a single cycle.
REQ-030 In MEM_ADR/MEM_RD/MEM_WR: alu_src=1, ext_op=1, alu_op=0. EXE_I: alu_op=2 (ori) or 3 (lui). EXE_R: alu_op=0 or 1 by funct.
REQ-031 All enables not listed for a state SHALL be 0; pc_wr, reg_wr and mem_wr SHALL never be high for more than one cycle per instruction.

Reset
REQ-032 reset high at a clock edge SHALL force state=FETCH, wait counter=0 and all outputs 0 on the next cycle, overriding any transition, including mid-MEM_WR (the pending write SHALL be suppressed).
REQ-033 The first cycle after reset is released SHALL be FETCH with ir_wr=1.

Structure
REQ-034 Opcode/funct codes, state codes, alu_op and wb_sel/reg_dst encodings SHALL live in the shared package mips_pkg.
REQ-035 One sub-module, mc_decode, SHALL be used: combinational opcode/funct -> instruction class; the FSM SHALL be in mc_ctrl.

Verification
REQ-036 Reset, then addu -> states 0,1,2,7; reg_wr=1 and reg_dst=1 in cycle 4; retire=1 once.
REQ-037 lw with MEM_WAIT=2 -> states 0,1,4,5,5,5,9 (7 cycles); reg_wr=1 only in the last cycle, with wb_sel=1.
REQ-038 beq with zero=1 and with zero=0 -> 3 cycles each, npc_sel=1 and pc_wr=1 in cycle 3 both times.
REQ-039 jal -> cycle 3: j=1, reg_wr=1, reg_dst=2, wb_sel=2; jr -> jr_ctrl=1, j=0.
REQ-040 opcode 111111 -> DECODE pulses illegal=1 with pc_wr=1, then FETCH; no reg_wr or mem_wr.
REQ-041 reset asserted during MEM_WR (MEM_WAIT=3) -> mem_wr never asserted, state=0 after the next edge.
